// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the raster timing generator: offset width,
// a sync-window pair and the clamp used to keep trimmed sync edges inside a line/frame.
package video_timing_pkg;

   localparam int OFF_W     = 4;   // width of the signed sync trims
   localparam int CNT_MAX_W = 16;  // widest axis counter the window type can hold

   typedef logic [CNT_MAX_W-1:0] cnt_t;

   // Effective sync window of one axis: active for start <= count < stop.
   typedef struct packed {
      cnt_t start;
      cnt_t stop;
   } sync_window_t;

   // Clamp a signed edge position into [0, total].
   function automatic cnt_t clamp_count(input int sum, input int total);
      if (sum < 0)
         return '0;
      if (sum > total)
         return cnt_t'(total);
      return cnt_t'(sum);
   endfunction

endpackage

// File: rtl/video_timing_if.sv
// Timing bundle between the generator (master) and the video output/scaler path (slave).
interface video_timing_if #(
   parameter int HW = 9,
   parameter int VW = 9
) ();
   import video_timing_pkg::*;

   logic                    clk_pix;
   logic signed [OFF_W-1:0] hs_offset;
   logic signed [OFF_W-1:0] vs_offset;
   logic [HW-1:0]           hc;
   logic [VW-1:0]           vc;
   logic                    hsync;
   logic                    vsync;
   logic                    hbl;
   logic                    vbl;
   logic                    de;
   logic                    line_start;
   logic                    frame_start;
   logic                    field;

   modport master (
      input  clk_pix, hs_offset, vs_offset,
      output hc, vc, hsync, vsync, hbl, vbl, de, line_start, frame_start, field
   );

   modport slave (
      output clk_pix, hs_offset, vs_offset,
      input  hc, vc, hsync, vsync, hbl, vbl, de, line_start, frame_start, field
   );
endinterface

// File: rtl/video_timing_axis.sv
// One raster axis: trimmed and clamped sync window, registered sync and blank.
// Works on the count the axis is about to present, so outputs line up with it.
module video_timing_axis
   import video_timing_pkg::*;
#(
   parameter int W        = 9,
   parameter int TOTAL    = 383,
   parameter int BL_START = 256,
   parameter int BL_END   = 383,   // BL_END == TOTAL: blanking runs to the axis end
   parameter int S_START  = 300,
   parameter int S_END    = 332,
   parameter bit POL      = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [W-1:0]            cnt_next,
   input  logic signed [OFF_W-1:0] offset,
   input  logic                    before_edge,  // other axis is still left of the sync edge position
   input  logic                    force_blank,
   output logic                    blank_next,
   output logic                    blank,
   output logic                    sync
);

   logic signed [W:0] off_ext;
   logic signed [W:0] start_sum;
   logic signed [W:0] end_sum;
   sync_window_t      win;
   cnt_t              cnt;
   logic              sync_next;

   // Window arithmetic in W+1 signed bits, then clamp and compare against the next count.
   // NOTE: every always_comb output is assigned on all paths, so no latch can be inferred.
   always_comb begin
      off_ext   = $signed({{(W + 1 - OFF_W){offset[OFF_W-1]}}, offset});
      start_sum = $signed({1'b0, W'(S_START)}) + off_ext;
      end_sum   = $signed({1'b0, W'(S_END)}) + off_ext;
      win.start = clamp_count(int'(start_sum), TOTAL);
      win.stop  = clamp_count(int'(end_sum), TOTAL);
      cnt       = cnt_t'(cnt_next);
      // Edges sit at the start of the edge line unless before_edge moves them mid-line.
      sync_next = ((cnt > win.start) || (cnt == win.start && !before_edge)) &&
                  ((cnt < win.stop)  || (cnt == win.stop  &&  before_edge));
      blank_next = force_blank ||
                   ((cnt >= cnt_t'(BL_START)) && ((cnt < cnt_t'(BL_END)) || (BL_END == TOTAL)));
   end

   // Register sync and blank on pixel enables; reset forces sync inactive at once.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync  <= ~POL;
         blank <= 1'b0;
      end else if (en) begin
         sync  <= sync_next ? POL : ~POL;
         blank <= blank_next;
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, blanking, trimmed sync,
// display enable and line/frame strobes, advancing only on clk_pix cycles.
// Sync trims are latched at the frame wrap and take effect from pixel 0 of line 0.
// Optional interlace support is built when VIDEO_TIMING_INTERLACE_EN is defined.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int HW        = 9,
   parameter int VW        = 9,
   parameter int HTOTAL    = 383,
   parameter int HBL_START = 256,
   parameter int HS_START  = 300,
   parameter int HS_END    = 332,
   parameter int VTOTAL    = 263,
   parameter int VBL_START = 223,
   parameter int VBL_END   = 263,
   parameter int VS_START  = 235,
   parameter int VS_END    = 243,
   parameter bit HS_POL    = 1'b1,
   parameter bit VS_POL    = 1'b1
) (
   input logic            clk,
   input logic            reset,
   video_timing_if.master vt
);

   localparam logic [HW-1:0] H_LAST = HW'(HTOTAL);
   localparam logic [VW-1:0] V_LAST = VW'(VTOTAL);
`ifdef VIDEO_TIMING_INTERLACE_EN
   localparam logic [HW-1:0] H_HALF  = HW'((HTOTAL + 1) / 2);
   localparam logic [VW-1:0] V_EXTRA = VW'(VTOTAL + 1);
`endif

   logic                    running;     // low until the first enable after reset
   logic signed [OFF_W-1:0] hs_off_q;
   logic signed [OFF_W-1:0] vs_off_q;
   logic signed [OFF_W-1:0] hs_off_eff;
   logic signed [OFF_W-1:0] vs_off_eff;
   logic                    h_wrap;
   logic                    last_line;
   logic                    frame_wrap;
   logic [HW-1:0]           hc_next;
   logic [VW-1:0]           vc_next;
   logic                    field_next;
   logic                    before_edge;
   logic                    extra_line;
   logic                    hbl_next;
   logic                    vbl_next;

   // Next raster position, field and the trims that apply to it.
   always_comb begin
      h_wrap = (vt.hc == H_LAST);
`ifdef VIDEO_TIMING_INTERLACE_EN
      last_line = vt.field ? (vt.vc == V_EXTRA) : (vt.vc == V_LAST);
`else
      last_line = (vt.vc == V_LAST);
`endif
      frame_wrap = running && h_wrap && last_line;

      // The first enable after reset restarts at the origin so both strobes mark it.
      if (!running) begin
         hc_next = '0;
         vc_next = '0;
      end else if (h_wrap) begin
         hc_next = '0;
         vc_next = last_line ? '0 : vt.vc + 1'b1;
      end else begin
         hc_next = vt.hc + 1'b1;
         vc_next = vt.vc;
      end

`ifdef VIDEO_TIMING_INTERLACE_EN
      field_next  = frame_wrap ? ~vt.field : vt.field;
      before_edge = field_next && (hc_next < H_HALF);
      extra_line  = (vc_next == V_EXTRA);
`else
      field_next  = 1'b0;
      before_edge = 1'b0;
      extra_line  = 1'b0;
`endif

      // A wrap on the latch cycle already uses the incoming trims for pixel 0 of line 0.
      hs_off_eff = frame_wrap ? vt.hs_offset : hs_off_q;
      vs_off_eff = frame_wrap ? vt.vs_offset : vs_off_q;
   end

   video_timing_axis #(
      .W(HW), .TOTAL(HTOTAL), .BL_START(HBL_START), .BL_END(HTOTAL),
      .S_START(HS_START), .S_END(HS_END), .POL(HS_POL)
   ) u_h_axis (
      .clk(clk), .reset(reset), .en(vt.clk_pix), .cnt_next(hc_next),
      .offset(hs_off_eff), .before_edge(1'b0), .force_blank(1'b0),
      .blank_next(hbl_next), .blank(vt.hbl), .sync(vt.hsync)
   );

   video_timing_axis #(
      .W(VW), .TOTAL(VTOTAL), .BL_START(VBL_START), .BL_END(VBL_END),
      .S_START(VS_START), .S_END(VS_END), .POL(VS_POL)
   ) u_v_axis (
      .clk(clk), .reset(reset), .en(vt.clk_pix), .cnt_next(vc_next),
      .offset(vs_off_eff), .before_edge(before_edge), .force_blank(extra_line),
      .blank_next(vbl_next), .blank(vt.vbl), .sync(vt.vsync)
   );

   // Counters, trim latch, field, display enable and one-clk strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         running        <= 1'b0;
         vt.hc          <= '0;
         vt.vc          <= '0;
         hs_off_q       <= '0;
         vs_off_q       <= '0;
         vt.de          <= 1'b0;
         vt.line_start  <= 1'b0;
         vt.frame_start <= 1'b0;
         vt.field       <= 1'b0;
      end else begin
         vt.line_start  <= 1'b0;
         vt.frame_start <= 1'b0;
         if (vt.clk_pix) begin
            running        <= 1'b1;
            vt.hc          <= hc_next;
            vt.vc          <= vc_next;
            vt.de          <= ~hbl_next & ~vbl_next;
            vt.line_start  <= !running || h_wrap;
            vt.frame_start <= !running || frame_wrap;
            vt.field       <= field_next;
            if (frame_wrap) begin
               hs_off_q <= vt.hs_offset;
               vs_off_q <= vt.vs_offset;
            end
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a small 32x20 raster.
// Define VIDEO_TIMING_INTERLACE_EN for both RTL and bench to cover interlace timing.
module tb_video_timing_gen;

   localparam int HT  = 31;  // last pixel
   localparam int VT  = 19;  // last line
   localparam int HBL = 24;
   localparam int VBL = 15;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   video_timing_if #(.HW(9), .VW(9)) vt ();

   video_timing_gen #(
      .HW(9), .VW(9), .HTOTAL(HT), .HBL_START(HBL), .HS_START(26), .HS_END(29),
      .VTOTAL(VT), .VBL_START(VBL), .VBL_END(VT), .VS_START(4), .VS_END(10),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .vt(vt)
   );

   typedef struct {
      logic signed [3:0] hs_new;     // trims driven mid-frame (latched for the next frame)
      logic signed [3:0] vs_new;
      int                hs_first;   // expected hsync window of this frame (-1: never)
      int                hs_last;
      int                hs_w;
      int                vs_rise;    // expected vsync rise/fall line (-1: never)
      int                vs_fall;
   } vec_t;

   typedef struct {
      int hs_first, hs_last, hs_cnt;
      int vs_rise_v, vs_rise_h, vs_fall_v, vs_fall_h;
      int vbl_first, vbl_last, hbl_first, hbl_last;
      int lines, de_cnt, seq_err, field, timeout;
   } stat_t;

   int n_checks = 0;
   int n_err    = 0;
   int idle_err = 0;
   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One pixel enable followed by one idle clk; returns the strobes seen after the enable.
   task automatic pix_step(output bit ls, output bit fs);
      @(negedge clk);
      vt.clk_pix = 1'b1;
      @(posedge clk);
      #1;
      ls = vt.line_start;
      fs = vt.frame_start;
      @(negedge clk);
      vt.clk_pix = 1'b0;
      @(posedge clk);
      #1;
      if (vt.line_start || vt.frame_start) idle_err++;
   endtask

   // Walk one frame starting at pixel 0 of line 0, applying new trims at line 5.
   task automatic measure_frame(input logic signed [3:0] hs_new, input logic signed [3:0] vs_new,
                                input int exp_field, output stat_t st);
      int exp_h = 0;
      int exp_v = 0;
      int last_v;
      bit ls, fs;
      bit done = 1'b0;
      st.hs_first = -1; st.hs_last = -1; st.hs_cnt = 0;
      st.vs_rise_v = -1; st.vs_rise_h = -1; st.vs_fall_v = -1; st.vs_fall_h = -1;
      st.vbl_first = -1; st.vbl_last = -1; st.hbl_first = -1; st.hbl_last = -1;
      st.lines = 0; st.de_cnt = 0; st.seq_err = 0; st.field = int'(vt.field);
      last_v = VT + exp_field;
      for (int s = 0; s < 2000 && !done; s++) begin
         if (int'(vt.hc) != exp_h || int'(vt.vc) != exp_v) st.seq_err++;
         if (vt.de != (!vt.hbl && !vt.vbl)) st.seq_err++;
         if (vt.hsync) begin
            st.hs_cnt++;
            if (st.hs_first < 0 || int'(vt.hc) < st.hs_first) st.hs_first = int'(vt.hc);
            if (int'(vt.hc) > st.hs_last) st.hs_last = int'(vt.hc);
         end
         if (vt.vsync && st.vs_rise_v < 0) begin
            st.vs_rise_v = int'(vt.vc);
            st.vs_rise_h = int'(vt.hc);
         end
         if (!vt.vsync && st.vs_rise_v >= 0 && st.vs_fall_v < 0) begin
            st.vs_fall_v = int'(vt.vc);
            st.vs_fall_h = int'(vt.hc);
         end
         if (vt.vbl) begin
            if (st.vbl_first < 0) st.vbl_first = int'(vt.vc);
            st.vbl_last = int'(vt.vc);
         end
         if (vt.hbl) begin
            if (st.hbl_first < 0 || int'(vt.hc) < st.hbl_first) st.hbl_first = int'(vt.hc);
            if (int'(vt.hc) > st.hbl_last) st.hbl_last = int'(vt.hc);
         end
         if (int'(vt.vc) + 1 > st.lines) st.lines = int'(vt.vc) + 1;
         if (vt.de) st.de_cnt++;
         if (vt.vc == 9'd5 && vt.hc == 9'd0) begin
            vt.hs_offset = hs_new;
            vt.vs_offset = vs_new;
         end
         pix_step(ls, fs);
         if (exp_h == HT) begin
            exp_h = 0;
            exp_v = (exp_v == last_v) ? 0 : exp_v + 1;
         end else begin
            exp_h++;
         end
         if (ls != (exp_h == 0)) st.seq_err++;
         if (fs != (exp_h == 0 && exp_v == 0)) st.seq_err++;
         done = fs;
      end
      st.timeout = done ? 0 : 1;
   endtask

   initial begin
      stat_t st;
      bit ls, fs;
      bit found;
      int exp_field, exp_lines, exp_rh;
      logic [25:0] snap;
      int frz_err;

      // Frame k shows the trims driven during frame k-1 (hand-computed, clamped to [0,31]/[0,19]).
      vecs[0] = '{4'sd3,  4'sd0,  26, 28, 3,  4, 10};
      vecs[1] = '{4'sh8,  4'sh8,  29, 30, 2,  4, 10};  // +3: end 32 clamps to 31
      vecs[2] = '{4'sd0,  4'sd7,  18, 20, 3,  0,  2};  // -8: vsync start -4 clamps to 0
      vecs[3] = '{4'sd7,  4'sd0,  26, 28, 3, 11, 17};
      vecs[4] = '{4'sd0,  4'sd0,  -1, -1, 0,  4, 10};  // +7: start==end==31, never
      vecs[5] = '{4'sd0,  4'sd0,  26, 28, 3,  4, 10};

      vt.clk_pix   = 1'b0;
      vt.hs_offset = 4'sd0;
      vt.vs_offset = 4'sd0;
      #12;
      check("rst_hc", int'(vt.hc), 0);
      check("rst_vc", int'(vt.vc), 0);
      check("rst_sync", int'({vt.hsync, vt.vsync}), 0);
      check("rst_blank_de", int'({vt.hbl, vt.vbl, vt.de}), 0);
      check("rst_strobes_field", int'({vt.line_start, vt.frame_start, vt.field}), 0);
      @(negedge clk);
      reset = 1'b0;

      pix_step(ls, fs);
      check("prime_strobes", int'({ls, fs}), 3);
      check("prime_pos", int'({vt.hc, vt.vc}), 0);

      for (int i = 0; i < 6; i++) begin
`ifdef VIDEO_TIMING_INTERLACE_EN
         exp_field = i % 2;
`else
         exp_field = 0;
`endif
         exp_lines = VT + 1 + exp_field;
         exp_rh    = (vecs[i].vs_rise < 0) ? -1 : (exp_field != 0 ? (HT + 1) / 2 : 0);
         measure_frame(vecs[i].hs_new, vecs[i].vs_new, exp_field, st);
         check($sformatf("f%0d_timeout", i), st.timeout, 0);
         check($sformatf("f%0d_seq", i), st.seq_err, 0);
         check($sformatf("f%0d_field", i), st.field, exp_field);
         check($sformatf("f%0d_lines", i), st.lines, exp_lines);
         check($sformatf("f%0d_hs_first", i), st.hs_first, vecs[i].hs_first);
         check($sformatf("f%0d_hs_last", i), st.hs_last, vecs[i].hs_last);
         check($sformatf("f%0d_hs_cnt", i), st.hs_cnt, vecs[i].hs_w * exp_lines);
         check($sformatf("f%0d_vs_rise_v", i), st.vs_rise_v, vecs[i].vs_rise);
         check($sformatf("f%0d_vs_rise_h", i), st.vs_rise_h, exp_rh);
         check($sformatf("f%0d_vs_fall_v", i), st.vs_fall_v, vecs[i].vs_fall);
         check($sformatf("f%0d_vs_fall_h", i), st.vs_fall_h, exp_rh);
         check($sformatf("f%0d_vbl_first", i), st.vbl_first, VBL);
         check($sformatf("f%0d_vbl_last", i), st.vbl_last, VT + exp_field);
         check($sformatf("f%0d_hbl_first", i), st.hbl_first, HBL);
         check($sformatf("f%0d_hbl_last", i), st.hbl_last, HT);
         check($sformatf("f%0d_de_cnt", i), st.de_cnt, HBL * VBL);
      end

      // Hold clk_pix low for 50 clks mid-line: everything frozen, strobes low.
      found = 1'b0;
      for (int s = 0; s < 100 && !found; s++) begin
         if (vt.hc == 9'd12) found = 1'b1;
         else pix_step(ls, fs);
      end
      check("freeze_reach", int'(found), 1);
      snap = {vt.hc, vt.vc, vt.hsync, vt.vsync, vt.hbl, vt.vbl, vt.de,
              vt.line_start, vt.frame_start, vt.field};
      frz_err = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if ({vt.hc, vt.vc, vt.hsync, vt.vsync, vt.hbl, vt.vbl, vt.de,
              vt.line_start, vt.frame_start, vt.field} != snap) frz_err++;
         if (vt.line_start || vt.frame_start) frz_err++;
      end
      check("freeze_hold", frz_err, 0);
      pix_step(ls, fs);
      check("resume_hc", int'(vt.hc), 13);

      // Reset between clk edges inside both sync pulses.
      found = 1'b0;
      for (int s = 0; s < 1000 && !found; s++) begin
         if (vt.hc == 9'd27 && vt.vc == 9'd5) found = 1'b1;
         else pix_step(ls, fs);
      end
      check("rst_reach", int'(found), 1);
      check("pre_rst_sync", int'({vt.hsync, vt.vsync}), 3);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_rst_sync", int'({vt.hsync, vt.vsync}), 0);
      check("async_rst_cnt", int'({vt.hc, vt.vc}), 0);
      @(negedge clk);
      reset = 1'b0;
      pix_step(ls, fs);
      check("post_rst_strobes", int'({ls, fs}), 3);
      check("post_rst_pos", int'({vt.hc, vt.vc}), 0);

      check("idle_strobes", idle_err, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
